hazard_stall_controller: RTL and testbench

Generates the per-stage `stall` and flush controls that drive the pipeline registers between IF/ID, ID/EX and EX/MEM. Each flush output is ORed into the target register's synchronous `reset`. The controller detects load-use hazards, taken branches resolved in EX, multi-cycle EX operations and external memory wait. It applies a fixed priority, and runs a small FSM that holds the pipeline for the duration of a multi-cycle operation.

---
 rtl/hazard_stall_controller.sv | 122 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush controller: load-use, taken branch, multi-cycle EX and memory wait.
// Optional stall-cycle performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int MULTI_CYCLES = 4,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ext_stall,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   ex_multi_start,
  output logic                   stall_pc,
  output logic                   stall_if_id,
  output logic                   stall_id_ex,
  output logic                   stall_ex_mem,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   flush_ex_mem,
  output logic                   multi_busy,
  output logic                   multi_done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, MULTI} state_e;

  localparam bit         MULTI_EN = (MULTI_CYCLES > 1);
  localparam logic [7:0] CNT_LOAD = 8'(MULTI_CYCLES - 2);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lu, ms;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign ms = ((state_q == IDLE) && ex_multi_start && MULTI_EN) ||
              ((state_q == MULTI) && (cnt_q != 8'd0));

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (reset) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (!ext_stall) begin
      case (state_q)
        IDLE: if (ex_multi_start && MULTI_EN) begin
          state_d = MULTI;
          cnt_d   = CNT_LOAD;
        end
        MULTI: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
               else               state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Priority: reset > ext_stall > multi > branch > load-use.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (reset) begin
      stall_pc = 1'b0;
    end else if (ext_stall) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
    end else if (ms) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (lu) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  assign multi_busy = (state_q == MULTI) && !reset;
  assign multi_done = !reset && !ext_stall &&
                      (((state_q == MULTI) && (cnt_q == 8'd0)) ||
                       ((state_q == IDLE) && ex_multi_start && !MULTI_EN));

`ifdef HAZARD_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (reset)                             stall_cycles_d = '0;
    else if (stall_pc && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) stall_cycles_q <= stall_cycles_d;

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: main (4-cycle), 1-cycle and 2-bit-counter instances.
module tb_hazard_stall_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ext_stall, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_multi_start;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic [8:0]  obs, obs1, obs2;
  logic [31:0] cyc_main;
  logic [1:0]  cyc_sat;
  logic [31:0] cyc_one;

  // {stall_pc, if_id, id_ex, ex_mem, f_if_id, f_id_ex, f_ex_mem, busy, done}
  localparam logic [8:0] Z  = 9'b0000_000_00;
  localparam logic [8:0] EX = 9'b1111_000_00;
  localparam logic [8:0] MS = 9'b1110_001_00;
  localparam logic [8:0] BR = 9'b0000_110_00;
  localparam logic [8:0] LU = 9'b1100_010_00;
  localparam logic [8:0] BY = 9'b0000_000_10;
  localparam logic [8:0] DN = 9'b0000_000_11;
  localparam logic [8:0] D1 = 9'b0000_000_01;

  int passed = 0, total = 0;
  logic [8:0]  exp_q [$];
  logic [31:0] cnt_q [$];

  `define DUT_PORTS(o, c) \
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .id_rs1(id_rs1), .id_rs2(id_rs2), \
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), \
    .ex_branch_taken(ex_branch_taken), .ex_multi_start(ex_multi_start), \
    .stall_pc(o[8]), .stall_if_id(o[7]), .stall_id_ex(o[6]), .stall_ex_mem(o[5]), \
    .flush_if_id(o[4]), .flush_id_ex(o[3]), .flush_ex_mem(o[2]), .multi_busy(o[1]), .multi_done(o[0]), \
    .stall_cycles(c)

  hazard_stall_controller #(.REG_ADDR_W(5), .MULTI_CYCLES(4), .STALL_CNT_W(32)) u_main (`DUT_PORTS(obs, cyc_main));
  hazard_stall_controller #(.REG_ADDR_W(5), .MULTI_CYCLES(1), .STALL_CNT_W(32)) u_one  (`DUT_PORTS(obs1, cyc_one));
  hazard_stall_controller #(.REG_ADDR_W(5), .MULTI_CYCLES(4), .STALL_CNT_W(2))  u_sat  (`DUT_PORTS(obs2, cyc_sat));

  // in = {reset, ext_stall, ex_mem_read, ex_branch_taken, ex_multi_start}
  task automatic drive(input logic [4:0] in);
    {reset, ext_stall, ex_mem_read, ex_branch_taken, ex_multi_start} = in;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_regs(input logic [4:0] rs1, rs2, rd, input logic u1, u2);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; id_uses_rs1 = u1; id_uses_rs2 = u2;
  endtask

  task automatic test_reset();
    logic [31:0] c;
    set_regs(5, 5, 5, 1, 1);
    drive(5'b11111); next_cycle();
    drive(5'b11111); exp_q.push_back(Z); cnt_q.push_back(0);
    @(negedge clk);
    total++;
    if (obs !== exp_q[0]) $display("FAIL reset_outputs got %b want %b", obs, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    c = cnt_q.pop_front(); total++;
    if (cyc_main !== c) $display("FAIL reset_counter got %0d want %0d", cyc_main, c); else passed++;
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [4:0]  in_t [0:5];
    logic [8:0]  ex_t [0:5];
    logic [14:0] rg_t [0:5];
    logic [8:0]  e;
    in_t = '{5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
    ex_t = '{LU, Z, Z, Z, LU, Z};
    // {rs1, rs2, rd}; uses bits set below per row
    rg_t = '{{5'd3, 5'd5, 5'd5}, {5'd3, 5'd5, 5'd5}, {5'd0, 5'd0, 5'd0},
             {5'd7, 5'd2, 5'd7}, {5'd7, 5'd2, 5'd7}, {5'd0, 5'd0, 5'd0}};
    for (int i = 0; i < 6; i++) begin
      set_regs(rg_t[i][14:10], rg_t[i][9:5], rg_t[i][4:0], (i >= 4), (i < 3));
      drive(in_t[i]); exp_q.push_back(ex_t[i]);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL load_use[%0d] got %b want %b", i, obs, e); else passed++;
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [4:0] in_t [0:4];
    logic [8:0] ex_t [0:4];
    logic [8:0] e;
    set_regs(5, 5, 5, 1, 1);
    // branch over lu, branch alone, ext over branch+lu, multi over branch, idle
    in_t = '{5'b00110, 5'b00010, 5'b01110, 5'b00011, 5'b00000};
    ex_t = '{BR, BR, EX, MS, Z};
    for (int i = 0; i < 5; i++) begin
      drive(in_t[i]); exp_q.push_back(ex_t[i]);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL priority[%0d] got %b want %b", i, obs, e); else passed++;
      next_cycle();
      // the multi row starts an op; let it drain before moving on
      if (i == 3) begin drive(5'b00000); repeat (4) next_cycle(); end
    end
  endtask

  task automatic test_multi(input string nm, input int n,
                            input logic [4:0] in_t [0:9], input logic [8:0] ex_t [0:9]);
    logic [8:0] e;
    set_regs(1, 2, 3, 0, 0);
    for (int i = 0; i < n; i++) begin
      drive(in_t[i]); exp_q.push_back(ex_t[i]);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s[%0d] got %b want %b", nm, i, obs, e); else passed++;
      next_cycle();
    end
  endtask

  task automatic test_multi1();
    logic [4:0] in_t [0:3];
    logic [8:0] ex_t [0:3];
    logic [8:0] e;
    in_t = '{5'b00001, 5'b00001, 5'b01001, 5'b00000};
    ex_t = '{D1, D1, EX, Z};
    for (int i = 0; i < 4; i++) begin
      drive(in_t[i]); exp_q.push_back(ex_t[i]);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs1 !== e) $display("FAIL multi1[%0d] got %b want %b", i, obs1, e); else passed++;
      next_cycle();
    end
  endtask

  task automatic test_perf();
    logic [31:0] c;
    logic        en;
`ifdef HAZARD_PERF_CNT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    set_regs(0, 5, 5, 0, 1);
    drive(5'b10000); next_cycle();
    drive(5'b00100); next_cycle();
    repeat (4) begin drive(5'b00001); next_cycle(); end
    drive(5'b00000);
    cnt_q.push_back(en ? 32'd4 : 32'd0); cnt_q.push_back(en ? 32'd3 : 32'd0);
    @(negedge clk);
    c = cnt_q.pop_front(); total++;
    if (cyc_main !== c) $display("FAIL perf_count got %0d want %0d", cyc_main, c); else passed++;
    c = cnt_q.pop_front(); total++;
    if ({30'd0, cyc_sat} !== c) $display("FAIL perf_sat got %0d want %0d", cyc_sat, c); else passed++;
    next_cycle();
    drive(5'b01000); next_cycle();
    drive(5'b00000);
    cnt_q.push_back(en ? 32'd5 : 32'd0); cnt_q.push_back(en ? 32'd3 : 32'd0);
    @(negedge clk);
    c = cnt_q.pop_front(); total++;
    if (cyc_main !== c) $display("FAIL perf_ext got %0d want %0d", cyc_main, c); else passed++;
    c = cnt_q.pop_front(); total++;
    if ({30'd0, cyc_sat} !== c) $display("FAIL perf_sat_hold got %0d want %0d", cyc_sat, c); else passed++;
    next_cycle();
  endtask

  initial begin
    logic [4:0] in_t [0:9];
    logic [8:0] ex_t [0:9];
    set_regs(0, 0, 0, 0, 0);
    drive(5'b10000);
    next_cycle();
    test_reset();
    drive(5'b10000); next_cycle();
    test_load_use();
    test_priority();

    in_t = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 0, 0, 0, 0, 0};
    ex_t = '{MS, MS|BY, MS|BY, DN, Z, Z, Z, Z, Z, Z};
    test_multi("multi4", 5, in_t, ex_t);

    in_t = '{5'b00001, 5'b01001, 5'b01001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 0, 0, 0};
    ex_t = '{MS, EX|BY, EX|BY, MS|BY, MS|BY, DN, Z, Z, Z, Z};
    test_multi("ext_mid", 7, in_t, ex_t);

    in_t = '{5'b00001, 5'b10001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 0, 0, 0};
    ex_t = '{MS, Z, MS, MS|BY, MS|BY, DN, Z, Z, Z, Z};
    test_multi("reset_mid", 7, in_t, ex_t);

    in_t = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 0};
    ex_t = '{MS, MS|BY, MS|BY, DN, MS, MS|BY, MS|BY, DN, Z, Z};
    test_multi("back_to_back", 9, in_t, ex_t);

    test_multi1();
    test_perf();

    if (exp_q.size() != 0 || cnt_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size() + cnt_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
